reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, 32, data width of each register and of the read/write data ports, in bits.
REQ-002 Parameter ADDR_W, 5, register address width; register count is 2**ADDR_W (32 registers).
REQ-003 clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 A1  input  ADDR_W  read port 1 address (rs); RD1 drives the ALU SrcA operand.
REQ-006 A2  input  ADDR_W  read port 2 address (rt); RD2 feeds the SrcB operand mux.
REQ-007 A3  input  ADDR_W  write address (rd or rt, selected upstream).
REQ-008 WE3  input  1  write enable for port 3.
REQ-009 WD3  input  WIDTH  write data (ALUResult or memory read data).
REQ-010 RD1  output  WIDTH  read data, port 1.
REQ-011 RD2  output  WIDTH  read data, port 2.

Function
REQ-012 Storage SHALL be 2**ADDR_W registers of WIDTH bits each.
REQ-013 Reads SHALL be combinational (asynchronous): RD1/RD2 SHALL reflect the current contents of register A1/A2 within the same cycle, with no clock latency.
REQ-014 Register 0 SHALL read as 0 on both ports at all times, regardless of any write history.
REQ-015 A write SHALL occur on the rising edge of clk when WE3=1, reset=0 and A3!=0, storing WD3 into register A3; the new value SHALL be visible on the read ports from the cycle after that edge.
REQ-016 A write with A3=0 SHALL be discarded with no side effect.
REQ-017 With WE3=0, no register SHALL change.
REQ-018 A1 and A2 SHALL be allowed to be equal; both ports SHALL then return identical data.
REQ-019 Read-during-write to the same address, with the bypass feature absent, SHALL return the old (pre-edge) value in that cycle.
REQ-020 Exactly one write port SHALL exist; there are no write-write conflicts.

Reset
REQ-021 On a rising edge of clk with reset=1, every register SHALL be cleared to 0.
REQ-022 Reset SHALL take priority over a simultaneous write; WE3/WD3 SHALL be ignored on that edge.
REQ-023 Before the first reset edge, register contents are undefined (X) except register 0, which reads 0; after the reset edge, RD1 and RD2 SHALL be 0 for any address.
REQ-024 Reset asserted mid-program SHALL clear all registers on the next edge; writes SHALL resume on the first edge with reset=0.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-026 With REGFILE_BYPASS_EN defined: when WE3=1, reset=0, A3!=0 and A3==A1 (or A2), RD1 (or RD2) SHALL return WD3 combinationally in the same cycle; register 0 SHALL still read 0.
REQ-027 With REGFILE_BYPASS_EN undefined: no forwarding; REQ-019 applies.

Verification
REQ-028 Reset for one cycle, then A1=5, A2=31 -> RD1=0, RD2=0.
REQ-029 WE3=1, A3=7, WD3=32'h00000007 for one edge; then A1=7, A2=7 -> RD1=RD2=32'h00000007.
REQ-030 WE3=1, A3=0, WD3=32'hDEADBEEF for one edge; then A1=0 -> RD1=0.
REQ-031 Register 9 holds 32'h1; WE3=1, A3=9, WD3=32'h2, A1=9 before the edge -> RD1=32'h1 without the macro, 32'h2 with REGFILE_BYPASS_EN; after the edge RD1=32'h2 in both builds.
REQ-032 reset=1 with WE3=1, A3=3, WD3=32'hFFFFFFFF on the same edge -> register 3 reads 0 afterwards.
REQ-033 Write registers 1..31 with value=index, then read all pairs (A1=i, A2=31-i) -> RD1=i and RD2=31-i, except index 0 reads 0.

Source files
------------

// File: rtl/reg_file_if.sv
// Bus bundle for the 3-port register file: two combinational read ports and one write port.
interface reg_file_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [ADDR_W-1:0] A3;
    logic              WE3;
    logic [WIDTH-1:0]  WD3;
    logic [WIDTH-1:0]  RD1;
    logic [WIDTH-1:0]  RD2;

    modport master (
        output A1, A2, A3, WE3, WD3,
        input  RD1, RD2
    );

    modport slave (
        input  A1, A2, A3, WE3, WD3,
        output RD1, RD2
    );
endinterface

// File: rtl/reg_file.sv
// 2**ADDR_W x WIDTH register file, register 0 hardwired to zero, synchronous reset.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_file #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    reg_file_if.slave   bus
);
    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [NREG-1:0][WIDTH-1:0] regs_q;
    logic [NREG-1:0][WIDTH-1:0] regs_d;
    logic                       wr_en_c;

    assign wr_en_c = bus.WE3 && (bus.A3 != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en_c) begin
            regs_d[bus.A3] = bus.WD3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Register 0 is masked at the read mux so it reads zero even before the first reset.
    always_comb begin
        bus.RD1 = '0;
        bus.RD2 = '0;
        if (bus.A1 != '0) begin
            bus.RD1 = regs_q[bus.A1];
`ifdef REGFILE_BYPASS_EN
            if (wr_en_c && !reset && (bus.A3 == bus.A1)) begin
                bus.RD1 = bus.WD3;
            end
`endif
        end
        if (bus.A2 != '0) begin
            bus.RD2 = regs_q[bus.A2];
`ifdef REGFILE_BYPASS_EN
            if (wr_en_c && !reset && (bus.A3 == bus.A2)) begin
                bus.RD2 = bus.WD3;
            end
`endif
        end
    end
endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow the REGFILE_BYPASS_EN build setting.
module tb_reg_file;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 5;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    reg_file_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    reg_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        bus.WE3 = 1'b1;
        bus.A3  = a;
        bus.WD3 = d;
        tick();
        bus.WE3 = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_byp;
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        bus.WE3 = 1'b0;
        bus.A1  = 5'd0;
        bus.A2  = 5'd0;
        bus.A3  = 5'd0;
        bus.WD3 = 32'h0;

        // Register 0 reads zero even before any reset edge
        #1;
        check("pre_reset_r0_rd1", bus.RD1, 32'h0);
        check("pre_reset_r0_rd2", bus.RD2, 32'h0);

        tick();
        reset  = 1'b0;
        bus.A1 = 5'd5;
        bus.A2 = 5'd31;
        #1;
        check("reset_rd1_a5", bus.RD1, 32'h0);
        check("reset_rd2_a31", bus.RD2, 32'h0);

        write_reg(5'd7, 32'h0000_0007);
        bus.A1 = 5'd7;
        bus.A2 = 5'd7;
        #1;
        check("wr7_rd1", bus.RD1, 32'h0000_0007);
        check("wr7_rd2", bus.RD2, 32'h0000_0007);

        write_reg(5'd0, 32'hDEAD_BEEF);
        bus.A1 = 5'd0;
        bus.A2 = 5'd0;
        #1;
        check("wr0_discard_rd1", bus.RD1, 32'h0);
        check("wr0_discard_rd2", bus.RD2, 32'h0);
        check("wr0_no_side_effect_r7", dut.regs_q[7], 32'h0000_0007);

        // Read-during-write on register 9
        write_reg(5'd9, 32'h0000_0001);
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'h0000_0002;
`else
        exp_byp = 32'h0000_0001;
`endif
        bus.WE3 = 1'b1;
        bus.A3  = 5'd9;
        bus.WD3 = 32'h0000_0002;
        bus.A1  = 5'd9;
        bus.A2  = 5'd9;
        #1;
        check("rdw_r9_rd1", bus.RD1, exp_byp);
        check("rdw_r9_rd2", bus.RD2, exp_byp);
        tick();
        bus.WE3 = 1'b0;
        #1;
        check("after_edge_r9_rd1", bus.RD1, 32'h0000_0002);

        // Same-cycle write to register 0 must not forward
        bus.WE3 = 1'b1;
        bus.A3  = 5'd0;
        bus.WD3 = 32'hCAFE_F00D;
        bus.A1  = 5'd0;
        #1;
        check("rdw_r0_no_forward", bus.RD1, 32'h0);
        bus.WE3 = 1'b0;

        // WE3=0 holds every register
        bus.A3  = 5'd9;
        bus.WD3 = 32'h1234_5678;
        tick();
        bus.A1 = 5'd9;
        bus.A2 = 5'd7;
        #1;
        check("we0_hold_r9", bus.RD1, 32'h0000_0002);
        check("we0_hold_r7", bus.RD2, 32'h0000_0007);

        // Reset beats a simultaneous write
        write_reg(5'd3, 32'h0000_0033);
        reset   = 1'b1;
        bus.WE3 = 1'b1;
        bus.A3  = 5'd3;
        bus.WD3 = 32'hFFFF_FFFF;
        tick();
        reset   = 1'b0;
        bus.WE3 = 1'b0;
        bus.A1  = 5'd3;
        bus.A2  = 5'd7;
        #1;
        check("reset_prio_r3", bus.RD1, 32'h0);
        check("reset_clears_r7", bus.RD2, 32'h0);

        // Writes resume on the first edge after reset deasserts
        write_reg(5'd4, 32'hA5A5_5A5A);
        bus.A1 = 5'd4;
        #1;
        check("post_reset_write_r4", bus.RD1, 32'hA5A5_5A5A);

        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'(i));
        end
        for (int i = 0; i < 32; i++) begin
            bus.A1 = 5'(i);
            bus.A2 = 5'(31 - i);
            #1;
            check($sformatf("sweep_rd1_%0d", i), bus.RD1, 32'(i));
            check($sformatf("sweep_rd2_%0d", 31 - i), bus.RD2, 32'(31 - i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
